tri_wave_analyzer: RTL and testbench
====================================

# tri_wave_analyzer

Receive-side checker for the 4-bit triangle stream produced by the audio tone path. It samples the waveform on each qualified clock and tracks slope direction with a small state machine. From that it reports period (in samples), peak, trough and lock status, and it counts malformed steps. It sits downstream of the tone generator in the audio channel, for self-test and for frequency readback.

## Interface
- DW, 4, sample width (unsigned)
- PW, 8, width of period and error counters

- base_freq  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_in  in  DW  waveform sample
- sample_valid  in  1  qualifies sample_in for this edge
- period  out  PW  samples between last two trough events
- period_valid  out  1  one-cycle pulse when period/trough update
- peak  out  DW  value held before last rise→fall turn
- trough  out  DW  value held before last fall→rise turn
- locked  out  1  last two reported periods equal, no error since
- err  out  1  one-cycle pulse on malformed step
- err_count  out  PW  saturating count of err pulses

## Operation
- States: IDLE, RISE, FALL. Internal registers:
  - p: previous accepted sample
  - cnt: samples since last trough event, PW bits, saturating at 2^PW-1
  - flat: last step was zero
  - seen_trough
  - last_period
- Only edges with sample_valid=1 do anything. With sample_valid=0, all state and outputs hold, except that the pulses return to 0.
- Step arithmetic uses DW+1-bit signed delta d = s − p. No wrap: 15→0 is d=−15, not +1.
- IDLE: p←s, cnt←1, go RISE, flat←0.
- RISE:
  - d=+1 → stay.
  - d=0 or d=−1 → turn: peak←p, go FALL.
  - Any other d → error.
- FALL:
  - d=−1 → stay.
  - d=0 or d=+1 → trough event: trough←p, go RISE.
  - Any other d → error.
- Flat rule: d=0 when flat=1 → error, in either state. flat←(d==0) on every accepted non-error step.
- Every accepted step: p←s, cnt←cnt+1 (saturating).
- Trough event:
  - If seen_trough=1: period←cnt+1 (saturating) and period_valid pulses.
  - Then cnt←0 and seen_trough←1.
- Lock: on each period report, locked←(seen a previous report) && (cnt+1 == last_period); then last_period←cnt+1.
- Error:
  - err pulses and err_count increments (saturating).
  - locked←0, seen_trough←0, last_period cleared.
  - Resync: p←s, cnt←1, flat←0, go RISE.
  - peak, trough and period retain their last values.
- Reference stream 0,1..15,15,14..1,0 repeated: trough events on each repeated 0; period=32, peak=15, trough=0.

## Timing
- Reset (rst_n=0, immediate):
  - State IDLE.
  - period, period_valid, peak, trough, locked, err and err_count all 0.
  - Internal registers 0.
- Reset mid-operation discards all history. The first valid sample after release is treated as the IDLE sample.
- Latency: an event caused by the sample at edge N is visible on outputs after edge N. period_valid and err are high for exactly one cycle.
- period_valid and err cannot both pulse on the same edge; an error step is never a trough event.
- err_count at 2^PW−1 stays; err still pulses.
- cnt saturation: the reported period is 2^PW−1, and lock compares saturated values.

## Test plan
- Reference stream (above), sample_valid=1, 4 periods:
  - period_valid pulses at 32-sample spacing; period=32, peak=15, trough=0.
  - locked=1 after the 2nd report; err_count=0.
- Same stream with 15→0 substituted mid-rise:
  - err pulses once; err_count=1; locked=0.
  - After two further trough events: period=32 again; locked re-asserts one report later.
- Reference stream with sample_valid toggling 1,0,1,0:
  - Reported period remains 32 (counts samples, not clocks); locked=1.
- Constant 0 for 10 valid samples (generator disabled):
  - err at samples 3, 5, 7 and 9; err_count=4; locked=0.
- Stream 4,5..9,9,8..5,4 repeated:
  - period=12, peak=9, trough=4; locked after the 2nd report.
- rst_n low for 1 cycle while locked with err_count=3:
  - All outputs read 0 immediately.
  - Reference stream resumes and relocks with period=32.

Source files
------------

// File: rtl/tri_wave_analyzer.sv
// tri_wave_analyzer: receive-side checker for the 4-bit triangle tone stream.
// It follows the slope of the accepted samples and reports the period between
// troughs, the latest peak and trough values, and lock status. It also counts
// malformed steps, meaning jumps larger than one code or two flat steps in a row.
module tri_wave_analyzer #(
    parameter int DW = 4,
    parameter int PW = 8
) (
    input  logic          base_freq,
    input  logic          rst_n,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic [PW-1:0] period,
    output logic          period_valid,
    output logic [DW-1:0] peak,
    output logic [DW-1:0] trough,
    output logic          locked,
    output logic          err,
    output logic [PW-1:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } state_t;

    localparam logic [PW-1:0]        CNT_MAX = '1;
    localparam logic [PW-1:0]        CNT_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic signed [DW:0]   D_ZERO  = '0;
    localparam logic signed [DW:0]   D_NEG1  = '1;
    localparam logic signed [DW:0]   D_POS1  = {{DW{1'b0}}, 1'b1};

    state_t          state;
    logic [DW-1:0]   p;
    logic [PW-1:0]   cnt;
    logic            flat;
    logic            seen_trough;
    logic [PW-1:0]   last_period;

    logic signed [DW:0] delta;
    logic            step_up;
    logic            step_zero;
    logic            step_down;
    logic            step_bad;
    logic            turn_evt;
    logic            trough_evt;
    logic [PW-1:0]   cnt_next;
    logic [PW-1:0]   err_count_next;
    logic            lock_match;

    // Classify the step from the previous accepted sample and flag slope turns.
    // The delta is one bit wider than a sample, so 15 -> 0 counts as a large
    // drop and is never treated as a wrap-around.
    always_comb begin
        delta          = $signed({1'b0, sample_in}) - $signed({1'b0, p});
        step_up        = (delta == D_POS1);
        step_zero      = (delta == D_ZERO);
        step_down      = (delta == D_NEG1);
        step_bad       = !(step_up || step_zero || step_down) || (step_zero && flat);
        turn_evt       = (state == RISE) && !step_bad && (step_zero || step_down);
        trough_evt     = (state == FALL) && !step_bad && (step_zero || step_up);
        cnt_next       = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        err_count_next = (err_count == CNT_MAX) ? err_count : err_count + CNT_ONE;
        // last_period is zero only when no report has been made since reset or
        // since the last error. A saturating cnt+1 is never zero, so the
        // nonzero test stands for "a previous report exists".
        lock_match     = (last_period != '0) && (cnt_next == last_period);
    end

    // Slope-tracking state machine with registered reporting outputs. The
    // pulse outputs drop back to zero on every edge that does not re-raise them.
    always_ff @(posedge base_freq or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            p            <= '0;
            cnt          <= '0;
            flat         <= 1'b0;
            seen_trough  <= 1'b0;
            last_period  <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            peak         <= '0;
            trough       <= '0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_count    <= '0;
        end else begin
            period_valid <= 1'b0;
            err          <= 1'b0;
            if (sample_valid) begin
                case (state)
                    IDLE: begin
                        p     <= sample_in;
                        cnt   <= CNT_ONE;
                        flat  <= 1'b0;
                        state <= RISE;
                    end
                    default: begin
                        if (step_bad) begin
                            // Malformed step: drop lock history and resynchronise
                            // on this sample as the start of a new rise.
                            err         <= 1'b1;
                            err_count   <= err_count_next;
                            locked      <= 1'b0;
                            seen_trough <= 1'b0;
                            last_period <= '0;
                            p           <= sample_in;
                            cnt         <= CNT_ONE;
                            flat        <= 1'b0;
                            state       <= RISE;
                        end else begin
                            p    <= sample_in;
                            flat <= step_zero;
                            cnt  <= cnt_next;
                            if (turn_evt) begin
                                peak  <= p;
                                state <= FALL;
                            end
                            if (trough_evt) begin
                                trough      <= p;
                                state       <= RISE;
                                cnt         <= '0;
                                seen_trough <= 1'b1;
                                if (seen_trough) begin
                                    period       <= cnt_next;
                                    period_valid <= 1'b1;
                                    locked       <= lock_match;
                                    last_period  <= cnt_next;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tri_wave_analyzer.sv
// tb_tri_wave_analyzer: directed and randomized stimulus for tri_wave_analyzer.
// Each edge is checked against a sample-level model built from the triangle
// rules: the size of each step, the direction of travel, and the distance
// between troughs.
module tb_tri_wave_analyzer;

    localparam int DW  = 4;
    localparam int PW  = 8;
    localparam int SAT = 255;

    logic          base_freq = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic [PW-1:0] period;
    logic          period_valid;
    logic [DW-1:0] peak;
    logic [DW-1:0] trough;
    logic          locked;
    logic          err;
    logic [PW-1:0] err_count;

    int total = 0;
    int bad = 0;

    // Reference model state.
    bit m_started;
    bit m_rising;
    bit m_lastFlat;
    int m_prev;
    int m_count;
    bit m_seenTrough;
    int m_lastReport;
    int e_period, e_pv, e_peak, e_trough, e_locked, e_err, e_errc;

    // Bench bookkeeping.
    int sampleIdx = 0;
    int errSeen = 0;
    bit trackSpacing = 0;
    int expSpacing = 0;
    int lastPv = -1;
    int pvSeen = 0;
    int errIdx[$];
    int exp4[4] = '{3, 5, 7, 9};

    always #5 base_freq = ~base_freq;

    tri_wave_analyzer #(.DW(DW), .PW(PW)) dut (
        .base_freq    (base_freq),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .period       (period),
        .period_valid (period_valid),
        .peak         (peak),
        .trough       (trough),
        .locked       (locked),
        .err          (err),
        .err_count    (err_count)
    );

    function automatic int satInc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_started    = 0;
        m_rising     = 1;
        m_lastFlat   = 0;
        m_prev       = 0;
        m_count      = 0;
        m_seenTrough = 0;
        m_lastReport = 0;
        e_period = 0; e_pv = 0; e_peak = 0; e_trough = 0;
        e_locked = 0; e_err = 0; e_errc = 0;
    endtask

    // One accepted sample. A legal step moves the value by at most one code,
    // and the value may not stay flat twice in a row. A step that moves against
    // the current direction, or stays flat, turns the wave. The turn at the
    // bottom closes one period.
    task automatic modelStep(input int s);
        int  d;
        int  n;
        bit  broken;
        bit  reversing;
        e_pv  = 0;
        e_err = 0;
        if (!m_started) begin
            m_started  = 1;
            m_prev     = s;
            m_count    = 1;
            m_rising   = 1;
            m_lastFlat = 0;
            return;
        end
        d = s - m_prev;
        broken = (d > 1) || (d < -1) || (d == 0 && m_lastFlat);
        if (broken) begin
            e_err        = 1;
            e_errc       = satInc(e_errc);
            e_locked     = 0;
            m_seenTrough = 0;
            m_lastReport = 0;
            m_prev       = s;
            m_count      = 1;
            m_lastFlat   = 0;
            m_rising     = 1;
            return;
        end
        n = satInc(m_count);
        reversing = m_rising ? (d <= 0) : (d >= 0);
        if (reversing && m_rising) begin
            e_peak   = m_prev;
            m_rising = 0;
            m_count  = n;
        end else if (reversing) begin
            e_trough = m_prev;
            m_rising = 1;
            if (m_seenTrough) begin
                e_period     = n;
                e_pv         = 1;
                e_locked     = (m_lastReport != 0) && (n == m_lastReport);
                m_lastReport = n;
            end
            m_count      = 0;
            m_seenTrough = 1;
        end else begin
            m_count = n;
        end
        m_lastFlat = (d == 0);
        m_prev     = s;
    endtask

    task automatic checkOutput();
        check("period",       32'(period),       32'(e_period));
        check("period_valid", 32'(period_valid), 32'(e_pv));
        check("peak",         32'(peak),         32'(e_peak));
        check("trough",       32'(trough),       32'(e_trough));
        check("locked",       32'(locked),       32'(e_locked));
        check("err",          32'(err),          32'(e_err));
        check("err_count",    32'(err_count),    32'(e_errc));
    endtask

    task automatic applyStimulus(input int s, input bit v);
        sample_in    = DW'(s);
        sample_valid = v;
        @(posedge base_freq);
        #1;
        if (v) begin
            sampleIdx++;
            modelStep(s);
        end else begin
            e_pv  = 0;
            e_err = 0;
        end
        checkOutput();
        if (err === 1'b1) errSeen++;
        if (trackSpacing && period_valid === 1'b1) begin
            if (lastPv >= 0) check("pv_spacing", 32'(sampleIdx - lastPv), 32'(expSpacing));
            lastPv = sampleIdx;
            pvSeen++;
        end
    endtask

    task automatic emit(input int s, input bit toggle);
        applyStimulus(s, 1'b1);
        if (toggle) applyStimulus(int'($urandom_range(0, 15)), 1'b0);
    endtask

    // One triangle: optional leading low value, rise to hi, repeat hi, fall to lo.
    task automatic feedTri(input int lo, input int hi, input bit includeLo, input bit toggle);
        if (includeLo) emit(lo, toggle);
        for (int v = lo + 1; v <= hi; v++) emit(v, toggle);
        emit(hi, toggle);
        for (int v = hi - 1; v >= lo; v--) emit(v, toggle);
    endtask

    task automatic startSpacing(input int sp);
        trackSpacing = 1;
        expSpacing   = sp;
        lastPv       = -1;
        pvSeen       = 0;
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic doReset();
        sample_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(posedge base_freq);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int lo;
        int hi;
        int s;
        modelReset();
        #2;
        doReset();

        // Reference stream, five triangles plus the closing trough.
        $display("[TB] reference stream");
        startSpacing(32);
        errSeen = 0;
        for (int r = 0; r < 5; r++) feedTri(0, 15, 1'b1, 1'b0);
        emit(0, 1'b0);
        check("ref_reports", 32'(pvSeen), 32'd4);
        check("ref_period", 32'(period), 32'd32);
        check("ref_peak", 32'(peak), 32'd15);
        check("ref_trough", 32'(trough), 32'd0);
        check("ref_locked", 32'(locked), 32'd1);
        check("ref_errs", 32'(err_count), 32'd0);

        // Rise that wraps 15 -> 0 instead of turning.
        $display("[TB] wrap glitch");
        trackSpacing = 0;
        errSeen = 0;
        for (int v = 1; v <= 15; v++) emit(v, 1'b0);
        emit(0, 1'b0);
        check("glitch_errcount", 32'(err_count), 32'd1);
        check("glitch_unlocked", 32'(locked), 32'd0);
        feedTri(0, 15, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) feedTri(0, 15, 1'b1, 1'b0);
        emit(0, 1'b0);
        check("glitch_err_pulses", 32'(errSeen), 32'd1);
        check("glitch_period", 32'(period), 32'd32);
        check("glitch_relocked", 32'(locked), 32'd1);

        // Valid toggling: period counts samples, not clocks.
        $display("[TB] toggled valid");
        startSpacing(32);
        feedTri(0, 15, 1'b0, 1'b1);
        for (int r = 0; r < 3; r++) feedTri(0, 15, 1'b1, 1'b1);
        emit(0, 1'b1);
        check("toggle_reports", 32'(pvSeen), 32'd4);
        check("toggle_period", 32'(period), 32'd32);
        check("toggle_locked", 32'(locked), 32'd1);
        trackSpacing = 0;

        // Generator disabled: constant zero.
        $display("[TB] constant zero");
        doReset();
        errIdx.delete();
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(0, 1'b1);
            if (err === 1'b1) errIdx.push_back(k);
        end
        check("const0_err_n", 32'(errIdx.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("const0_err_at", 32'((i < errIdx.size()) ? errIdx[i] : -1), 32'(exp4[i]));
        check("const0_errcount", 32'(err_count), 32'd4);
        check("const0_locked", 32'(locked), 32'd0);

        // Reduced amplitude stream 4..9.
        $display("[TB] small triangle");
        doReset();
        startSpacing(12);
        for (int r = 0; r < 4; r++) feedTri(4, 9, 1'b1, 1'b0);
        emit(4, 1'b0);
        check("small_reports", 32'(pvSeen), 32'd3);
        check("small_period", 32'(period), 32'd12);
        check("small_peak", 32'(peak), 32'd9);
        check("small_trough", 32'(trough), 32'd4);
        check("small_locked", 32'(locked), 32'd1);
        trackSpacing = 0;

        // Three errors, then lock, then reset while locked.
        $display("[TB] reset while locked");
        doReset();
        emit(0, 1'b0);
        emit(5, 1'b0);
        emit(10, 1'b0);
        emit(1, 1'b0);
        for (int r = 0; r < 4; r++) feedTri(0, 15, 1'b1, 1'b0);
        emit(0, 1'b0);
        check("pre_reset_locked", 32'(locked), 32'd1);
        check("pre_reset_errcount", 32'(err_count), 32'd3);
        doReset();
        for (int r = 0; r < 4; r++) feedTri(0, 15, 1'b1, 1'b0);
        emit(0, 1'b0);
        check("post_reset_period", 32'(period), 32'd32);
        check("post_reset_locked", 32'(locked), 32'd1);
        check("post_reset_errcount", 32'(err_count), 32'd0);

        // Randomized triangles with gaps and occasional corrupt samples.
        $display("[TB] random triangles");
        for (int t = 0; t < 40; t++) begin
            int seq[$];
            lo = int'($urandom_range(0, 12));
            hi = int'($urandom_range(lo + 1, 15));
            seq.delete();
            for (int v = lo; v <= hi; v++) seq.push_back(v);
            if ($urandom_range(0, 1) == 1) seq.push_back(hi);
            for (int v = hi - 1; v >= lo; v--) seq.push_back(v);
            if ($urandom_range(0, 1) == 1) seq.push_back(lo);
            foreach (seq[i]) begin
                while ($urandom_range(0, 3) == 0) applyStimulus(int'($urandom_range(0, 15)), 1'b0);
                s = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 15)) : seq[i];
                applyStimulus(s, 1'b1);
            end
        end

        // Error counter saturation.
        $display("[TB] error saturation");
        doReset();
        for (int k = 0; k < 260; k++) applyStimulus((k % 2 == 1) ? 8 : 0, 1'b1);
        check("sat_errcount", 32'(err_count), 32'd255);
        applyStimulus(0, 1'b1);
        check("sat_err_pulse", 32'(err), 32'd1);
        check("sat_errcount_hold", 32'(err_count), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
